// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instr_prefetch_pkg;

  localparam int unsigned PC_W_DEF   = 9;
  localparam int unsigned INS_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned INSTR_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_fifo_sync.sv
// First-word-fall-through queue holding {pc, instruction} entries.
module fifo_sync #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic             do_push, do_pop;

  // Guard against overflow and popping an empty queue.
  assign do_push = push_i & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one outstanding memory read feeding a small FWFT queue,
// with redirect (branch) flush and stale-response dropping.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned INS_W = INS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             instr_valid,
  output logic [INS_W-1:0] instr,
  output logic [PC_W-1:0]  instr_pc,
  input  logic             instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_X = CNT_W + 1;
  localparam int unsigned ENT_W = PC_W + INS_W;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic             req_q, req_d;
  logic [PC_W-1:0]  pc_inc;
  logic             push, pop, flush;
  logic [CNT_W-1:0] count;
  logic [CNT_X-1:0] occupancy, count_after;
  logic [ENT_W-1:0] head;

  assign pc_inc      = fetch_pc_q + PC_W'(INSTR_STEP);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign occupancy   = {1'b0, count} + CNT_X'(state_q == ST_REQ);
  assign count_after = {1'b0, count} + CNT_X'(1) - CNT_X'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  // Next state: a request only launches when its result has a reserved slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!redirect && (occupancy < CNT_X'(DEPTH))) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect) begin
          state_d = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack && (count_after >= CNT_X'(DEPTH))) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls; the request address only moves when a request (re)launches.
  always_comb begin
    push       = 1'b0;
    flush      = redirect;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = (state_d != ST_IDLE);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if ((state_q == ST_REQ) && imem_ack) begin
      push       = 1'b1;
      fetch_pc_d = pc_inc;
    end
    if (state_d == ST_REQ) addr_d = fetch_pc_d;
  end

  fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({fetch_pc_q, imem_rdata}),
    .pop_i       (pop),
    .flush_i     (flush),
    .valid_o     (instr_valid),
    .data_o      (head),
    .count_o     (count)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr_pc  = head[ENT_W-1 -: PC_W];
  assign instr     = head[INS_W-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-level reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_instr_prefetch;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int PC_MASK = (1 << PC_W) - 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] w;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [INS_W-1:0] imem_rdata = '0;
  logic             redirect = 1'b0;
  logic [PC_W-1:0]  redirect_pc = '0;
  logic             instr_valid;
  logic [INS_W-1:0] instr;
  logic [PC_W-1:0]  instr_pc;
  logic             instr_ready = 1'b0;

  logic resp_ack = 1'b0;
  logic force_ack = 1'b0;
  int   lat = 0;
  int   wait_cnt = 0;

  int n_cmp = 0;
  int n_fail = 0;

  assign imem_ack = resp_ack | force_ack;

  instr_prefetch #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory: acks after 'lat' extra wait cycles, data = 0x13 + address.
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (wait_cnt >= lat) begin
        resp_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
    imem_rdata = 32'h13 + 32'(imem_addr);
  end

  // Reference model: expected request/queue contents after each rising edge.
  ent_t       m_q[$];
  bit         m_busy = 0;
  bit         m_stale = 0;
  int         m_fpc = 0;
  int         m_addr = 0;
  bit         live = 0;

  always @(posedge clk) begin
    int pre;
    bit was_busy;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_stale = 0; m_fpc = 0; m_addr = 0;
      live = 1;
    end else if (live) begin
      pre = m_q.size();
      was_busy = m_busy;
      if (pre > 0 && instr_ready && !redirect) void'(m_q.pop_front());
      if (redirect) m_q.delete();
      if (was_busy && imem_ack) begin
        m_busy = 0;
        if (!m_stale && !redirect) begin
          e.pc = PC_W'(m_addr);
          e.w  = imem_rdata;
          m_q.push_back(e);
          m_fpc = (m_fpc + 4) & PC_MASK;
          if (m_q.size() < DEPTH) begin
            m_busy = 1;
            m_addr = m_fpc;
          end
        end
        m_stale = 0;
      end else if (was_busy) begin
        if (redirect) m_stale = 1;
      end else if (!redirect && pre < DEPTH) begin
        m_busy = 1;
        m_addr = m_fpc;
      end
      if (redirect) m_fpc = int'(redirect_pc);
    end
    #1;
    if (live) begin
      chk("imem_req", 64'(imem_req), 64'(m_busy));
      if (m_busy) chk("imem_addr", 64'(imem_addr), 64'(m_addr));
      chk("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instr_pc", 64'(instr_pc), 64'(m_q[0].pc));
        chk("instr", 64'(instr), 64'(m_q[0].w));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset two cycles, checks reset outputs, leaves reset asserted.
  task automatic hold_reset(input int l, input bit rdy);
    reset = 1'b1;
    redirect = 1'b0;
    force_ack = 1'b0;
    lat = l;
    instr_ready = rdy;
    cyc(2);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (imem_req !== 1'b1 && k < 8) begin cyc(1); k++; end
    if (imem_req !== 1'b1) chk({nm, "_timeout"}, 64'(imem_req), 64'd1);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (instr_valid !== 1'b1 && k < 12) begin cyc(1); k++; end
    if (instr_valid !== 1'b1) chk({nm, "_timeout"}, 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);

    // Zero-wait stream, ready high; spurious ack right after release is ignored.
    hold_reset(0, 1'b1);
    reset = 1'b0; force_ack = 1'b1;
    cyc(1);
    force_ack = 1'b0;
    chk("a_req_first", 64'(imem_req), 64'd1);
    chk("a_addr_first", 64'(imem_addr), 64'd0);
    chk("a_valid_c2", 64'(instr_valid), 64'd0);
    cyc(1);
    chk("a_valid_c3", 64'(instr_valid), 64'd1);
    chk("a_pc0", 64'(instr_pc), 64'd0);
    chk("a_ins0", 64'(instr), 64'h13);
    cyc(1); chk("a_pc4", 64'(instr_pc), 64'd4);
    cyc(1); chk("a_pc8", 64'(instr_pc), 64'd8);
    cyc(1); chk("a_pc12", 64'(instr_pc), 64'd12);
    chk("a_ins12", 64'(instr), 64'h1f);

    // Ready low: queue fills with 4 entries, then a single pop refetches at 16.
    hold_reset(0, 1'b0);
    reset = 1'b0;
    cyc(5);
    chk("b_req_full", 64'(imem_req), 64'd0);
    chk("b_head", 64'(instr_pc), 64'd0);
    cyc(2);
    chk("b_req_still", 64'(imem_req), 64'd0);
    instr_ready = 1'b1;
    cyc(1);
    instr_ready = 1'b0;
    wait_req("b_refetch");
    chk("b_addr16", 64'(imem_addr), 64'd16);
    chk("b_head4", 64'(instr_pc), 64'd4);
    cyc(3);

    // Slow memory, redirect while waiting: stale ack dropped, refetch at 0x40.
    hold_reset(2, 1'b1);
    reset = 1'b0;
    cyc(1);
    chk("c_req", 64'(imem_req), 64'd1);
    cyc(1);
    redirect = 1'b1; redirect_pc = 9'h040;
    cyc(1);
    redirect = 1'b0;
    chk("c_drop_req", 64'(imem_req), 64'd1);
    chk("c_drop_addr", 64'(imem_addr), 64'd0);
    cyc(1);
    chk("c_idle_req", 64'(imem_req), 64'd0);
    chk("c_no_stale", 64'(instr_valid), 64'd0);
    wait_req("c_refetch");
    chk("c_addr40", 64'(imem_addr), 64'h40);
    wait_valid("c_first");
    chk("c_pc40", 64'(instr_pc), 64'h40);
    chk("c_ins40", 64'(instr), 64'h53);

    // Redirect coinciding with an ack while two entries are queued.
    hold_reset(0, 1'b0);
    reset = 1'b0;
    cyc(3);
    chk("d_head", 64'(instr_pc), 64'd0);
    redirect = 1'b1; redirect_pc = 9'h080;
    cyc(1);
    redirect = 1'b0;
    chk("d_valid_low", 64'(instr_valid), 64'd0);
    chk("d_req_low", 64'(imem_req), 64'd0);
    cyc(1);
    chk("d_addr80", 64'(imem_addr), 64'h80);
    cyc(1);
    chk("d_pc80", 64'(instr_pc), 64'h80);

    // PC wrap from 0x1FC to 0x000.
    hold_reset(0, 1'b1);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 9'h1fc;
    cyc(1);
    redirect = 1'b0;
    chk("e_req_idle", 64'(imem_req), 64'd0);
    cyc(1);
    chk("e_addr1fc", 64'(imem_addr), 64'h1fc);
    cyc(1);
    chk("e_pc1fc", 64'(instr_pc), 64'h1fc);
    cyc(1);
    chk("e_pc_wrap", 64'(instr_pc), 64'h000);
    chk("e_ins_wrap", 64'(instr), 64'h13);

    // Reset while a request is pending and its ack arrives in the reset cycle.
    hold_reset(1, 1'b0);
    reset = 1'b0;
    cyc(4);
    chk("f_pre_valid", 64'(instr_valid), 64'd1);
    chk("f_pre_addr", 64'(imem_addr), 64'd4);
    reset = 1'b1;
    cyc(1);
    chk("f_req_low", 64'(imem_req), 64'd0);
    chk("f_empty", 64'(instr_valid), 64'd0);
    reset = 1'b0;
    cyc(1);
    chk("f_addr0", 64'(imem_addr), 64'd0);
    chk("f_req_again", 64'(imem_req), 64'd1);
    instr_ready = 1'b1;
    wait_valid("f_first");
    chk("f_pc0", 64'(instr_pc), 64'd0);

    // Mixed traffic: one-wait memory, bursty ready, redirects (one near the wrap).
    hold_reset(1, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      instr_ready = (i % 3 != 0);
      redirect = (i == 17) || (i == 30);
      redirect_pc = (i == 17) ? 9'h120 : 9'h1f8;
      cyc(1);
    end
    redirect = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter PC_W SHALL have default 9 and set the width of every program-counter signal.
REQ-002 Parameter INS_W SHALL have default 32 and set the instruction width.
REQ-003 Parameter DEPTH SHALL have default 4 and set the number of queue entries; it SHALL be a power of 2 and at least 2.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  registered read request to instruction memory.
REQ-007 imem_addr  output  PC_W  byte address of the current request.
REQ-008 imem_ack  input  1  memory has returned data for the current request this cycle.
REQ-009 imem_rdata  input  INS_W  instruction word; valid only when imem_ack is high.
REQ-010 redirect  input  1  branch or jump taken: flush the queue and refetch.
REQ-011 redirect_pc  input  PC_W  new fetch address; sampled only when redirect is high.
REQ-012 instr_valid  output  1  the head queue entry is available.
REQ-013 instr  output  INS_W  instruction word of the head entry.
REQ-014 instr_pc  output  PC_W  address of the head entry.
REQ-015 instr_ready  input  1  the datapath consumes the head entry this cycle.

Function
REQ-016 The block SHALL keep at most one memory request outstanding.
  - imem_req and imem_addr SHALL stay stable from assertion until the cycle in which imem_ack is high.
REQ-017 FSM states SHALL be IDLE, REQ (waiting for ack) and DROP (waiting for the ack of a stale request); imem_req SHALL be high exactly in REQ and DROP.
REQ-018 Occupancy SHALL equal the queue count plus 1 if the state is REQ; IDLE SHALL move to REQ when occupancy < DEPTH and redirect is low.
REQ-019 In REQ, on imem_ack with redirect low:
  - write {fetch_pc, imem_rdata} to the queue tail;
  - set fetch_pc to fetch_pc+4, truncated modulo 2^PC_W;
  - stay in REQ if count+1-pop < DEPTH, otherwise go to IDLE.
REQ-020 With a zero-wait memory (ack in the same cycle as the request), the block SHALL sustain one instruction per cycle.
REQ-021 A redirect in IDLE SHALL load fetch_pc from redirect_pc and flush the queue; the state SHALL stay IDLE.
REQ-022 A redirect in REQ without ack SHALL load fetch_pc, flush the queue and go to DROP.
REQ-023 A redirect in REQ with ack in the same cycle SHALL discard imem_rdata, load fetch_pc, flush the queue and go to IDLE.
REQ-024 In DROP, imem_ack SHALL discard imem_rdata and go to IDLE.
  - A further redirect while in DROP SHALL reload fetch_pc and stay in DROP.
  - imem_addr SHALL keep the stale address until the ack.
REQ-025 The queue SHALL be first-word-fall-through.
  - instr_valid SHALL be high when the count is nonzero.
  - A pop SHALL occur when instr_valid and instr_ready are both high.
REQ-026 A push and a pop in the same cycle SHALL leave the count unchanged.
  - Pushes SHALL never overflow, because REQ-018 reserves a slot.
  - A pop on an empty queue SHALL be ignored.
REQ-027 Flush SHALL take priority over pop in the same cycle; instr_valid SHALL be low in the cycle after any redirect.
REQ-028 Latency: the first entry SHALL be visible on instr/instr_valid in the cycle after the cycle in which the memory acks.

Reset
REQ-029 On reset the block SHALL set:
  - fetch_pc = 0, state = IDLE, queue count = 0 and the read/write pointers to 0;
  - imem_req = 0, imem_addr = 0, instr_valid = 0.
REQ-030 Reset SHALL take priority over redirect and imem_ack.
  - Reset asserted mid-request SHALL abandon the request without entering DROP.
  - Any ack in the first cycle after reset is released SHALL be ignored.
REQ-031 imem_req SHALL first assert in the second cycle after reset is released.

Structure
REQ-032 The shared package SHALL define:
  - PC_W and INS_W defaults;
  - the instruction step constant 4;
  - the fetch FSM state enum (IDLE, REQ, DROP).
REQ-033 Queue storage and pointers SHALL be a sub-module fifo_sync, parameterised by width (PC_W+INS_W) and DEPTH, with push/pop/flush/count ports.

Verification
REQ-034 Reset released, zero-wait memory returning word 0x00000013 + addr, instr_ready held high:
  - instr_pc sequence 0, 4, 8, 12;
  - instr_valid high from the third cycle onward.
REQ-035 instr_ready held low with a zero-wait memory:
  - exactly 4 entries are fetched (pcs 0, 4, 8, 12), then imem_req drops;
  - one ready pulse then causes a fetch at pc 16.
REQ-036 Memory with a 3-cycle ack, redirect to 0x40 one cycle after the request:
  - the stale ack is discarded;
  - the next request has imem_addr = 0x40;
  - the first instr_pc = 0x40.
REQ-037 Redirect to 0x80 in the same cycle as an ack, with the queue holding 2 entries:
  - instr_valid is low in the next cycle;
  - the next request has imem_addr = 0x80;
  - no stale entry appears.
REQ-038 fetch_pc = 0x1FC with a zero-wait memory: the next instr_pc after 0x1FC is 0x000 (wrap).
REQ-039 Reset asserted while in REQ with ack pending:
  - imem_req is low in the next cycle;
  - the queue is empty;
  - the first request after release has imem_addr = 0.
